// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Loads a controller transition table from a byte stream.
//             Stream: A5, N, N x {addr, next, out}, checksum (XOR of N and
//             all entry bytes). Each entry produces one table write strobe.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             prog_enable       - programming request; rising edge starts load
//             in_data/in_valid  - byte stream in, in_ready - byte accepted
//             wr_en/wr_addr/wr_next/wr_out - transition-table write port
//             run_enable        - table is valid, controller may run
//             busy, done        - load in progress / one-cycle success pulse
//             error, err_code   - sticky failure flag and its cause
//  Revision : 1.0  initial release
// ============================================================================
module prog_loader #(
  parameter int STATE_COUNT = 8,
  parameter int STATE_WIDTH = $clog2(STATE_COUNT),
  parameter int IN_WIDTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_enable,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          wr_en,
  output logic [STATE_WIDTH+IN_WIDTH-1:0] wr_addr,
  output logic [STATE_WIDTH-1:0]        wr_next,
  output logic [7:0]                    wr_out,
  output logic                          run_enable,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [1:0]                    err_code
);

  localparam int ADDR_WIDTH = STATE_WIDTH + IN_WIDTH;

  localparam logic [1:0] ERR_ABORT = 2'd0;
  localparam logic [1:0] ERR_HDR   = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_HDR   = 4'd1,
    S_CNT   = 4'd2,
    S_B0    = 4'd3,
    S_B1    = 4'd4,
    S_B2    = 4'd5,
    S_WRITE = 4'd6,
    S_CSUM  = 4'd7,
    S_RUN   = 4'd8,
    S_ERR   = 4'd9
  } state_t;

  state_t                  state;
  logic                    prog_enable_q;
  logic                    start;
  logic [7:0]              count;
  logic [7:0]              csum;
  logic [ADDR_WIDTH-1:0]   addr_lat;
  logic [STATE_WIDTH-1:0]  next_lat;

  // Address byte: nothing above the {state,input} field, state index in range.
  function automatic logic addr_ok(input logic [7:0] b);
    addr_ok = ((32'(b) >> ADDR_WIDTH) == 32'd0) &&
              ((32'(b) >> IN_WIDTH) < STATE_COUNT);
  endfunction

  // Next-state byte: nothing above the state field, index in range.
  function automatic logic next_ok(input logic [7:0] b);
    next_ok = ((32'(b) >> STATE_WIDTH) == 32'd0) && (32'(b) < STATE_COUNT);
  endfunction

  assign start    = prog_enable & ~prog_enable_q;
  // Both are pure decodes of the state register.
  assign in_ready = state inside {S_HDR, S_CNT, S_B0, S_B1, S_B2, S_CSUM};
  assign busy     = state inside {S_HDR, S_CNT, S_B0, S_B1, S_B2, S_WRITE, S_CSUM};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      prog_enable_q <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_next       <= '0;
      wr_out        <= '0;
      run_enable    <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= ERR_ABORT;
      count         <= '0;
      csum          <= '0;
      addr_lat      <= '0;
      next_lat      <= '0;
    end else begin
      prog_enable_q <= prog_enable;
      wr_en         <= 1'b0;
      done          <= 1'b0;

      if (start) begin
        // A new load overrides whatever the FSM was doing; any byte or
        // write that coincides with it is dropped.
        state      <= S_HDR;
        run_enable <= 1'b0;
        error      <= 1'b0;
        err_code   <= ERR_ABORT;
        csum       <= '0;
      end else if (busy && !prog_enable) begin
        // Request withdrawn mid-load: abort without taking the byte.
        state      <= S_ERR;
        error      <= 1'b1;
        err_code   <= ERR_ABORT;
        run_enable <= 1'b0;
      end else begin
        case (state)
          S_HDR: begin
            if (in_valid) begin
              if (in_data == 8'hA5) begin
                state <= S_CNT;
              end else begin
                state    <= S_ERR;
                error    <= 1'b1;
                err_code <= ERR_HDR;
              end
            end
          end

          S_CNT: begin
            if (in_valid) begin
              count <= in_data;
              csum  <= csum ^ in_data;
              state <= (in_data == 8'd0) ? S_CSUM : S_B0;
            end
          end

          S_B0: begin
            if (in_valid) begin
              csum <= csum ^ in_data;
              if (addr_ok(in_data)) begin
                addr_lat <= ADDR_WIDTH'(in_data);
                state    <= S_B1;
              end else begin
                state    <= S_ERR;
                error    <= 1'b1;
                err_code <= ERR_RANGE;
              end
            end
          end

          S_B1: begin
            if (in_valid) begin
              csum <= csum ^ in_data;
              if (next_ok(in_data)) begin
                next_lat <= STATE_WIDTH'(in_data);
                state    <= S_B2;
              end else begin
                state    <= S_ERR;
                error    <= 1'b1;
                err_code <= ERR_RANGE;
              end
            end
          end

          S_B2: begin
            if (in_valid) begin
              // Write port is loaded here so the strobe lines up with the
              // single WRITE cycle; otherwise it holds its last value.
              csum    <= csum ^ in_data;
              wr_en   <= 1'b1;
              wr_addr <= addr_lat;
              wr_next <= next_lat;
              wr_out  <= in_data;
              state   <= S_WRITE;
            end
          end

          S_WRITE: begin
            count <= count - 8'd1;
            state <= (count == 8'd1) ? S_CSUM : S_B0;
          end

          S_CSUM: begin
            if (in_valid) begin
              if (in_data == csum) begin
                state      <= S_RUN;
                done       <= 1'b1;
                run_enable <= 1'b1;
              end else begin
                state    <= S_ERR;
                error    <= 1'b1;
                err_code <= ERR_CSUM;
              end
            end
          end

          S_ERR: begin
            run_enable <= 1'b0;
          end

          default: begin
            // IDLE and RUN wait for the next start.
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Self-checking bench for prog_loader: directed streams plus
//             randomized streams with random in_valid gaps, checked against
//             a stream-level parsing model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prog_enable = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [2:0] wr_next;
  logic [7:0] wr_out;
  logic       run_enable;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .prog_enable(prog_enable),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_next    (wr_next),
    .wr_out     (wr_out),
    .run_enable (run_enable),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0]  stream[$];
  logic [17:0] exp_w[$];
  logic [17:0] obs_w[$];
  int          exp_n;
  bit          exp_ok;
  logic [1:0]  exp_code;
  int          done_cnt;
  int          done_cycle;
  int          hdr_cycle;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) obs_w.push_back({wr_addr, wr_next, wr_out});
    if (done) begin
      done_cnt++;
      done_cycle = cyc;
    end
  end

  // Reference: parse the stream by the format rules alone.
  task automatic run_model();
    int n;
    int p;
    logic [7:0] x;
    logic [7:0] a;
    logic [7:0] nx;
    logic [7:0] o;
    exp_w.delete();
    exp_ok   = 1'b0;
    exp_code = 2'd0;
    if (stream[0] != 8'hA5) begin
      exp_code = 2'd1;
      exp_n    = 1;
      return;
    end
    n = int'(stream[1]);
    x = stream[1];
    p = 2;
    for (int e = 0; e < n; e++) begin
      a = stream[p];
      if (a >= 8'd128 || (a / 16) >= 8) begin
        exp_code = 2'd2;
        exp_n    = p + 1;
        return;
      end
      nx = stream[p + 1];
      if (nx >= 8'd8) begin
        exp_code = 2'd2;
        exp_n    = p + 2;
        return;
      end
      o = stream[p + 2];
      x = x ^ a ^ nx ^ o;
      exp_w.push_back({a[6:0], nx[2:0], o});
      p += 3;
    end
    exp_n = p + 1;
    if (stream[p] == x) exp_ok = 1'b1;
    else exp_code = 2'd3;
  endtask

  task automatic do_start();
    @(negedge clk);
    in_valid    = 1'b0;
    prog_enable = 1'b0;
    @(negedge clk);
    prog_enable = 1'b1;
  endtask

  task automatic send_bytes(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int  waited;
      bit  sent;
      waited = 0;
      sent   = 1'b0;
      while (!sent) begin
        @(negedge clk);
        in_data  = stream[i];
        in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (in_valid && in_ready) begin
          sent = 1'b1;
          if (i == 0) hdr_cycle = cyc;
        end else begin
          waited++;
          if (waited > 100) begin
            check_val("byte_timeout", 32'(i), 32'(n));
            @(negedge clk);
            in_valid = 1'b0;
            return;
          end
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_case(input string name, input bit gaps);
    obs_w.delete();
    done_cnt = 0;
    do_start();
    @(negedge clk);
    check_val({name, "_start_run"}, 32'(run_enable), 32'd0);
    check_val({name, "_start_busy"}, 32'(busy), 32'd1);
    check_val({name, "_start_err"}, 32'(error), 32'd0);
    run_model();
    send_bytes(exp_n, gaps);
    repeat (4) @(negedge clk);
    check_val({name, "_done"}, 32'(done_cnt), 32'(exp_ok));
    check_val({name, "_error"}, 32'(error), 32'(!exp_ok));
    check_val({name, "_code"}, 32'(err_code), 32'(exp_code));
    check_val({name, "_run"}, 32'(run_enable), 32'(exp_ok));
    check_val({name, "_ready"}, 32'(in_ready), 32'd0);
    check_val({name, "_busy"}, 32'(busy), 32'd0);
    check_val({name, "_nwr"}, 32'(obs_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
      check_val({name, "_wr"}, 32'(obs_w[i]), 32'(exp_w[i]));
    if (!gaps && exp_ok)
      check_val({name, "_latency"}, 32'(done_cycle - hdr_cycle),
                32'(3 + 4 * exp_w.size()));
  endtask

  task automatic gen_random();
    int n;
    int kind;
    int bad;
    logic [7:0] x;
    logic [7:0] a;
    logic [7:0] nx;
    logic [7:0] o;
    stream.delete();
    n    = $urandom_range(0, 4);
    kind = $urandom_range(0, 9);
    bad  = (n > 0) ? $urandom_range(0, n - 1) : 0;
    stream.push_back(kind == 0 ? (8'hA5 ^ 8'($urandom_range(1, 255))) : 8'hA5);
    stream.push_back(8'(n));
    x = 8'(n);
    for (int e = 0; e < n; e++) begin
      a  = 8'($urandom_range(0, 127));
      nx = 8'($urandom_range(0, 7));
      o  = 8'($urandom_range(0, 255));
      if (kind == 1 && e == bad) a  = a | 8'h80;
      if (kind == 2 && e == bad) nx = 8'($urandom_range(8, 255));
      stream.push_back(a);
      stream.push_back(nx);
      stream.push_back(o);
      x = x ^ a ^ nx ^ o;
    end
    if (kind == 3) x = x ^ 8'($urandom_range(1, 255));
    stream.push_back(x);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_ready", 32'(in_ready), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_run", 32'(run_enable), 32'd0);
    check_val("rst_err", 32'({error, err_code, done, wr_en}), 32'd0);
    rst = 1'b0;

    stream = '{8'hA5, 8'h01, 8'h25, 8'h03, 8'h7E, 8'h59};
    run_case("one_entry", 1'b0);
    stream = '{8'hA5, 8'h00, 8'h00};
    run_case("empty", 1'b0);
    stream = '{8'h3C};
    run_case("bad_hdr", 1'b0);
    stream = '{8'hA5, 8'h01, 8'h25, 8'h0B, 8'h00, 8'h00};
    run_case("bad_next", 1'b0);
    stream = '{8'hA5, 8'h01, 8'h25, 8'h03, 8'h7E, 8'h58};
    run_case("bad_csum", 1'b0);

    for (int k = 0; k < 40; k++) begin
      gen_random();
      run_case("rand", ($urandom_range(0, 1) == 1));
    end

    // Abort: request drops while a byte is offered in B0.
    obs_w.delete();
    do_start();
    stream = '{8'hA5, 8'h01};
    send_bytes(2, 1'b0);
    @(negedge clk);
    in_data     = 8'h25;
    in_valid    = 1'b1;
    prog_enable = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("abort_error", 32'(error), 32'd1);
    check_val("abort_code", 32'(err_code), 32'd0);
    check_val("abort_ready", 32'(in_ready), 32'd0);
    check_val("abort_nwr", 32'(obs_w.size()), 32'd0);

    // Reset in the middle of a load.
    do_start();
    stream = '{8'hA5, 8'h02, 8'h25};
    send_bytes(3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_ready", 32'(in_ready), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_flags", 32'({wr_en, run_enable, done, error, err_code}), 32'd0);
    check_val("midrst_wport", 32'({wr_addr, wr_next, wr_out}), 32'd0);
    rst         = 1'b0;
    prog_enable = 1'b0;
    repeat (2) @(negedge clk);
    check_val("idle_after_rst", 32'({in_ready, busy}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
